// File: rtl/digit_scan_pkg.sv
// Shared types and helpers for the display scan controller.
// The timer width is sized so it can hold the larger of the two reload values.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  // Reload values are ticks-1, so $clog2 of the larger tick count is enough (min 1 bit).
  function automatic int tcnt_width(input int on_ticks, input int blank_ticks);
    int m;
    m = (on_ticks > blank_ticks) ? on_ticks : blank_ticks;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/digit_scanner_slot_timer.sv
// Loadable down-counter with a terminal-count flag; holds at zero until reloaded.
module slot_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (clear) begin
      tcnt <= '0;
    end else if (load) begin
      tcnt <= load_val;
    end else if (tcnt != '0) begin
      tcnt <= tcnt - W'(1);
    end
  end

  assign tc = (tcnt == '0);

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed anode scan for N-digit 7-segment displays with blanking gap,
// per-digit mask latched at slot start, enable and frame-start strobe.
module digit_scanner
  import digit_scan_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int ON_TICKS         = 100000,
  parameter int BLANK_TICKS      = 1000,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int IDX_W            = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [IDX_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int CW = tcnt_width(ON_TICKS, BLANK_TICKS);
  localparam logic [CW-1:0] ON_LOAD    = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam bit            NO_BLANK   = (BLANK_TICKS == 0);
  localparam logic [CW-1:0] SLOT_LOAD  = NO_BLANK ? ON_LOAD : BLANK_LOAD;

  scan_state_t           state_reg;
  logic [IDX_W-1:0]      digit_sel_reg;
  logic [NUM_DIGITS-1:0] act_reg;
  logic                  frame_start_reg;

  logic [IDX_W-1:0]      next_sel;
  logic [IDX_W-1:0]      entry_sel;
  logic [NUM_DIGITS-1:0] entry_hot;
  logic [NUM_DIGITS-1:0] act_next;
  logic                  t_clear;
  logic                  t_load;
  logic [CW-1:0]         t_val;
  logic                  tc;

  assign next_sel = (digit_sel_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_sel_reg + IDX_W'(1);

  // Digit whose ON phase would start on this edge, depending on where we come from.
  always_comb begin
    entry_sel = digit_sel_reg;
    case (state_reg)
      IDLE:    entry_sel = '0;
      ON:      entry_sel = next_sel;
      default: entry_sel = digit_sel_reg;
    endcase
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_decode
    assign entry_hot[gi] = (entry_sel == IDX_W'(gi));
  end

  // Mask is sampled only here, at ON entry, so mid-slot changes wait for the next slot.
  assign act_next = entry_hot & digit_mask;

  always_comb begin
    t_clear = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    if (!en) begin
      t_clear = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          t_load = 1'b1;
          t_val  = SLOT_LOAD;
        end
        BLANK: if (tc) begin
          t_load = 1'b1;
          t_val  = ON_LOAD;
        end
        ON: if (tc) begin
          t_load = 1'b1;
          t_val  = SLOT_LOAD;
        end
        default: t_clear = 1'b1;
      endcase
    end
  end

  slot_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (t_clear),
    .load     (t_load),
    .load_val (t_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      digit_sel_reg   <= '0;
      act_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      if (!en) begin
        state_reg     <= IDLE;
        digit_sel_reg <= '0;
        act_reg       <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            digit_sel_reg   <= '0;
            frame_start_reg <= 1'b1;
            if (NO_BLANK) begin
              state_reg <= ON;
              act_reg   <= act_next;
            end else begin
              state_reg <= BLANK;
              act_reg   <= '0;
            end
          end
          BLANK: begin
            if (tc) begin
              state_reg <= ON;
              act_reg   <= act_next;
            end
          end
          ON: begin
            if (tc) begin
              digit_sel_reg   <= next_sel;
              frame_start_reg <= (next_sel == '0);
              if (NO_BLANK) begin
                state_reg <= ON;
                act_reg   <= act_next;
              end else begin
                state_reg <= BLANK;
                act_reg   <= '0;
              end
            end
          end
          default: begin
            state_reg     <= IDLE;
            digit_sel_reg <= '0;
            act_reg       <= '0;
          end
        endcase
      end
    end
  end

  assign digit_sel   = digit_sel_reg;
  assign anode       = (ANODE_ACTIVE_LOW != 0) ? ~act_reg : act_reg;
  assign blank       = ~|act_reg;
  assign frame_start = frame_start_reg;

endmodule
